// File: rtl/instruction_loader.sv
// Debug program loader: assembles UART bytes MSB-first into 32-bit words and
// writes them to instruction memory, holding the PC until a halt word or a full memory.
module instruction_loader #(
  parameter int          ADDR_W     = 8,
  parameter logic [7:0]  START_BYTE = 8'h4C,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [31:0]       data_instruction,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_instruction,
  output logic              stopPC_debug,
  output logic              load_done,
  output logic              load_full,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, FINISH, DONE} state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX   = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q;
  logic [1:0]          byte_cnt_q;
  logic [31:0]         word_q;
  logic [31:0]         word_d;
  logic [ADDR_W-1:0]   ptr_q;
  logic                close_q;
  logic [31:0]         data_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                wr_q;
  logic                stop_q;
  logic                done_q;
  logic                full_q;
  logic [ADDR_W:0]     count_q;
  logic                start_hit;

  assign word_d    = {word_q[23:0], rx_data};
  assign start_hit = rx_done && (rx_data == START_BYTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      ptr_q      <= '0;
      close_q    <= 1'b0;
      data_q     <= '0;
      wr_addr_q  <= '0;
      wr_q       <= 1'b0;
      stop_q     <= 1'b1;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_hit) begin
            state_q    <= LOAD;
            byte_cnt_q <= '0;
            ptr_q      <= '0;
            wr_addr_q  <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
            stop_q     <= 1'b1;
          end
        end
        LOAD: begin
          // close_q spends the write-pulse cycle before FINISH so the PC is
          // released a full cycle after the last memory write.
          if (close_q) begin
            close_q <= 1'b0;
            state_q <= FINISH;
          end else if (rx_done) begin
            word_q <= word_d;
            if (byte_cnt_q == 2'd3) begin
              byte_cnt_q <= '0;
              data_q     <= word_d;
              wr_addr_q  <= ptr_q;
              wr_q       <= 1'b1;
              if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
              if (word_d == HALT_WORD) begin
                close_q <= 1'b1;
              end else if (ptr_q == PTR_MAX) begin
                full_q  <= 1'b1;
                close_q <= 1'b1;
              end
              if (ptr_q != PTR_MAX) ptr_q <= ptr_q + 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        FINISH: begin
          state_q <= DONE;
          stop_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign data_instruction = data_q;
  assign wr_addr          = wr_addr_q;
  assign wr_instruction   = wr_q;
  assign stopPC_debug     = stop_q;
  assign load_done        = done_q;
  assign load_full        = full_q;
  assign word_count       = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed and random byte streams against a
// session-level model, on a 256-word instance and a 4-word instance.
module tb_instruction_loader;

  typedef struct packed {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data0 = '0, rx_data1 = '0;
  logic rx_done0 = 1'b0, rx_done1 = 1'b0;

  logic [31:0] data0, data1;
  logic [7:0]  addr0;
  logic [1:0]  addr1;
  logic        wr0, wr1, stop0, stop1, done0, done1, full0, full1;
  logic [8:0]  count0;
  logic [2:0]  count1;

  instruction_loader #(.ADDR_W(8)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data0), .rx_done(rx_done0),
    .data_instruction(data0), .wr_addr(addr0), .wr_instruction(wr0),
    .stopPC_debug(stop0), .load_done(done0), .load_full(full0), .word_count(count0));

  instruction_loader #(.ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data1), .rx_done(rx_done1),
    .data_instruction(data1), .wr_addr(addr1), .wr_instruction(wr1),
    .stopPC_debug(stop1), .load_done(done1), .load_full(full1), .word_count(count1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  wr_t obs0[$], obs1[$], exp0[$], exp1[$];
  int  long_pulse = 0;
  logic prev_wr0 = 1'b0, prev_wr1 = 1'b0;

  always @(posedge clk) begin
    #1;
    if (wr0) obs0.push_back('{cyc: cyc, addr: addr0, data: data0});
    if (wr1) obs1.push_back('{cyc: cyc, addr: {6'd0, addr1}, data: data1});
    if ((wr0 && prev_wr0) || (wr1 && prev_wr1)) long_pulse++;
    prev_wr0 = wr0;
    prev_wr1 = wr1;
  end

  // Session-level reference model, one slot per instance.
  int          m_depth[2] = '{256, 4};
  bit          m_loading[2];
  logic [31:0] m_acc[2];
  int          m_nb[2], m_ptr[2], m_count[2], m_close[2], m_wraddr[2];
  bit          m_full[2], m_done[2], m_stop[2];
  logic [31:0] m_data[2];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_loading[k] = 0; m_acc[k] = '0; m_nb[k] = 0; m_ptr[k] = 0; m_count[k] = 0;
    m_close[k] = -100; m_wraddr[k] = 0; m_full[k] = 0; m_done[k] = 0; m_stop[k] = 1;
    m_data[k] = '0;
  endtask

  task automatic model_byte(input int k, input logic [7:0] b, input int e);
    wr_t w;
    // The session is closed for two edges after the last write is accepted.
    if (e > m_close[k] && e <= m_close[k] + 2) return;
    if (!m_loading[k]) begin
      if (b == 8'h4C) begin
        m_loading[k] = 1; m_nb[k] = 0; m_ptr[k] = 0; m_count[k] = 0;
        m_done[k] = 0; m_full[k] = 0; m_stop[k] = 1; m_wraddr[k] = 0;
      end
      return;
    end
    m_acc[k] = {m_acc[k][23:0], b};
    m_nb[k]++;
    if (m_nb[k] < 4) return;
    m_nb[k] = 0;
    w.cyc = e; w.addr = 8'(m_ptr[k]); w.data = m_acc[k];
    if (k == 0) exp0.push_back(w); else exp1.push_back(w);
    m_data[k] = m_acc[k];
    m_wraddr[k] = m_ptr[k];
    if (m_count[k] < m_depth[k]) m_count[k]++;
    if (m_acc[k] == 32'hFFFF_FFFF || m_ptr[k] == m_depth[k] - 1) begin
      m_full[k] = (m_acc[k] != 32'hFFFF_FFFF);
      m_loading[k] = 0; m_close[k] = e; m_stop[k] = 0; m_done[k] = 1;
    end else begin
      m_ptr[k]++;
    end
  endtask

  task automatic drive(input int k, input logic [7:0] b);
    if (k == 0) begin rx_data0 = b; rx_done0 = 1'b1; end
    else        begin rx_data1 = b; rx_done1 = 1'b1; end
    model_byte(k, b, cyc + 1);
    @(negedge clk);
    rx_done0 = 1'b0;
    rx_done1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_word(input int k, input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      drive(k, w[8*i +: 8]);
      idle(gap);
    end
  endtask

  task automatic check_writes(input int k);
    wr_t o, x;
    if (k == 0) begin
      chk("nwrites0", 72'(obs0.size()), 72'(exp0.size()));
      while (obs0.size() > 0 && exp0.size() > 0) begin
        o = obs0.pop_front(); x = exp0.pop_front();
        $display("[TB] dut0 write cyc=%0d addr=%0d data=%h", o.cyc, o.addr, o.data);
        chk("write0", o, x);
      end
      obs0.delete(); exp0.delete();
    end else begin
      chk("nwrites1", 72'(obs1.size()), 72'(exp1.size()));
      while (obs1.size() > 0 && exp1.size() > 0) begin
        o = obs1.pop_front(); x = exp1.pop_front();
        $display("[TB] dut1 write cyc=%0d addr=%0d data=%h", o.cyc, o.addr, o.data);
        chk("write1", o, x);
      end
      obs1.delete(); exp1.delete();
    end
  endtask

  task automatic check_status(input int k);
    if (k == 0) begin
      chk("stop0",  72'(stop0),  72'(m_stop[k]));
      chk("done0",  72'(done0),  72'(m_done[k]));
      chk("full0",  72'(full0),  72'(m_full[k]));
      chk("count0", 72'(count0), 72'(m_count[k]));
      chk("addr0",  72'(addr0),  72'(m_wraddr[k]));
      chk("data0",  72'(data0),  72'(m_data[k]));
      chk("wr0",    72'(wr0),    72'd0);
    end else begin
      chk("stop1",  72'(stop1),  72'(m_stop[k]));
      chk("done1",  72'(done1),  72'(m_done[k]));
      chk("full1",  72'(full1),  72'(m_full[k]));
      chk("count1", 72'(count1), 72'(m_count[k]));
      chk("addr1",  72'(addr1),  72'(m_wraddr[k]));
      chk("data1",  72'(data1),  72'(m_data[k]));
      chk("wr1",    72'(wr1),    72'd0);
    end
  endtask

  initial begin
    logic [31:0] prog[2];
    logic [31:0] w;
    logic [7:0]  b;
    int          nw;

    prog[0] = 32'h1234_5678;
    prog[1] = 32'hFFFF_FFFF;
    model_reset(0);
    model_reset(1);

    // Reset state
    idle(3);
    rst = 1'b0;
    idle(2);
    check_status(0);
    check_status(1);

    // Non-start bytes in IDLE are ignored
    drive(0, 8'h00); idle(5);
    drive(0, 8'h41); idle(5);
    check_writes(0);
    check_status(0);

    // Spaced program, with exact release timing around the halt word
    drive(0, 8'h4C); idle(9);
    drive_word(0, prog[0], 9);
    for (int i = 3; i >= 1; i--) begin drive(0, prog[1][8*i +: 8]); idle(9); end
    drive(0, prog[1][7:0]);
    chk("halt_wr",    72'(wr0),   72'd1);
    chk("halt_addr",  72'(addr0), 72'd1);
    chk("halt_stop1", 72'(stop0), 72'd1);
    idle(1);
    chk("halt_wr_off", 72'(wr0),   72'd0);
    chk("halt_stop2",  72'(stop0), 72'd1);
    idle(1);
    chk("halt_stop3", 72'(stop0), 72'd0);
    chk("halt_done",  72'(done0), 72'd1);
    idle(3);
    check_writes(0);
    check_status(0);

    // Same program, back-to-back bytes
    drive(0, 8'h4C);
    drive_word(0, prog[0], 0);
    drive_word(0, prog[1], 0);
    idle(5);
    check_writes(0);
    check_status(0);

    // Random sessions with random gaps and noise between them
    for (int s = 0; s < 4; s++) begin
      b = 8'($urandom);
      if (b == 8'h4C) b = 8'h00;
      drive(0, b); idle($urandom_range(0, 3));
      drive(0, 8'h4C); idle($urandom_range(0, 2));
      nw = $urandom_range(1, 5);
      for (int i = 0; i < nw; i++) drive_word(0, $urandom, $urandom_range(0, 2));
      drive_word(0, 32'hFFFF_FFFF, $urandom_range(0, 1));
      idle(4);
      check_writes(0);
      check_status(0);
    end

    // 4-word instance: memory fills without a halt word, then a halt-terminated refill
    drive(1, 8'h4C);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      w[31] = 1'b0;
      drive_word(1, w, $urandom_range(0, 1));
    end
    idle(4);
    check_writes(1);
    check_status(1);
    drive(1, 8'h4C);
    drive_word(1, 32'h0000_0013, 0);
    drive_word(1, 32'hFFFF_FFFF, 0);
    idle(4);
    check_writes(1);
    check_status(1);

    // Reset in the middle of a session
    drive(0, 8'h4C);
    drive_word(0, 32'hDEAD_BEEF, 1);
    drive(0, 8'h11); drive(0, 8'h22);
    idle(2);
    check_writes(0);
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    idle(2);
    rst = 1'b0;
    idle(1);
    check_status(0);
    check_status(1);
    drive(0, 8'h4C);
    drive_word(0, 32'hFFFF_FFFF, 0);
    idle(4);
    check_writes(0);
    check_status(0);

    // Reload from DONE freezes the PC on the next edge and restarts at address 0
    drive(0, 8'h4C);
    chk("reload_stop", 72'(stop0), 72'd1);
    chk("reload_done", 72'(done0), 72'd0);
    drive_word(0, 32'hAABB_CCDD, 0);
    drive_word(0, 32'hFFFF_FFFF, 2);
    idle(4);
    check_writes(0);
    check_status(0);

    chk("pulse_width", 72'(long_pulse), 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Debug-side program loader that writes the instruction memory feeding the fetch stage. It consumes a byte stream from the UART receiver, assembles 32-bit instruction words MSB-first, and issues one write per word on the `data_instruction`/`wr_instruction` port. It holds the PC with `stopPC_debug` until a complete program, terminated by a halt word, has been stored.

## Interface
- `ADDR_W`, 8: instruction-memory address width; depth is 2^ADDR_W words.
- `START_BYTE`, 8'h4C: command byte ('L') that opens a load session.
- `HALT_WORD`, 32'hFFFF_FFFF: terminator instruction; it is written, then the session closes.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_done`=1.
- `rx_done`  in  1  one-cycle byte-valid strobe from the UART receiver.
- `data_instruction`  out  32  word to write into instruction memory.
- `wr_addr`  out  ADDR_W  word address for the write.
- `wr_instruction`  out  1  one-cycle write strobe.
- `stopPC_debug`  out  1  high = PC frozen (fetch must not advance).
- `load_done`  out  1  high once a session has closed.
- `load_full`  out  1  session closed because memory filled without a halt word.
- `word_count`  out  ADDR_W+1  number of words written in the current or last session.

## Operation
- FSM states: IDLE, LOAD, FINISH, DONE.
- IDLE: on `rx_done` with `rx_data`==START_BYTE, go to LOAD; clear byte counter, `wr_addr`, `word_count`, `load_done`, `load_full`. Other bytes are ignored.
- LOAD: each `rx_done` shifts `rx_data` into the word shift register (`word` = {word[23:0], rx_data}). The 2-bit byte counter increments on each byte.
- On the 4th byte (counter==3): register `data_instruction` = assembled word and `wr_addr` = current write pointer, and pulse `wr_instruction` for one cycle. Then increment the pointer and `word_count`, and clear the byte counter.
- If the completed word == HALT_WORD, go to FINISH.
- Else, if the pointer was 2^ADDR_W-1, set `load_full`=1 and go to FINISH.
- Else, stay in LOAD.
- FINISH: one cycle; then go to DONE, `stopPC_debug`<=0, `load_done`<=1.
- DONE: PC runs. A START_BYTE re-enters LOAD, with `stopPC_debug`<=1 on the same edge, `load_done`<=0, and counters cleared. Other bytes are ignored.
- START_BYTE inside LOAD is ordinary data, not a command.
- The write pointer never wraps. Full memory always ends the session.

## Timing
- Reset values:
  - FSM state = IDLE.
  - `stopPC_debug`=1: the CPU stays frozen until the first program loads.
  - `wr_instruction`=0, `data_instruction`=0, `wr_addr`=0.
  - `load_done`=0, `load_full`=0, `word_count`=0.
- Latency: the 4th byte is sampled at edge E. `wr_instruction`=1 during cycle E..E+1, with data and address stable for that whole cycle.
- Back-to-back bytes: `rx_done` may be asserted every cycle. No byte is lost, including a byte that arrives during a `wr_instruction` cycle.
- Halt word completed at edge E:
  - Write pulse in cycle E..E+1.
  - FINISH state at E+1.
  - `stopPC_debug` falls and `load_done` rises at E+2.
- The write pulse therefore always precedes PC release by at least one full cycle, so the memory write (posedge) lands before the negedge-clocked PC leaves its frozen value.
- `rx_done` during FINISH is ignored.
- Reset mid-session: immediate return to reset values, and the partial word is discarded. Already-written memory words are not touched.
- `word_count` counts the halt word. It saturates at 2^ADDR_W.

## Test plan
- Reset then idle: bytes 8'h00, 8'h41 -> no `wr_instruction`; `stopPC_debug`=1, `load_done`=0.
- 8'h4C, then 12 - 34 - 56 - 78 - FF - FF - FF - FF, one byte every 10 cycles:
  - Pulse 1: `wr_addr`=0, data 32'h12345678.
  - Pulse 2: `wr_addr`=1, data 32'hFFFFFFFF.
  - `stopPC_debug` falls 2 cycles after the 8th `rx_done`; `word_count`=2, `load_full`=0.
- Same stream with `rx_done` on consecutive cycles -> identical writes, with exactly one-cycle pulses and no dropped bytes.
- ADDR_W=2, 8'h4C followed by 4 non-halt words -> writes at addresses 0..3, then `load_full`=1, `load_done`=1, `stopPC_debug`=0, `word_count`=4.
- `rst` pulsed after 8'h4C and 6 data bytes -> only 1 write seen before reset; afterwards all outputs are at reset values. A new session starts writing again at `wr_addr`=0.
- After DONE, send 8'h4C -> `stopPC_debug`=1 on the next edge; the next word written lands at `wr_addr`=0.
